// File: rtl/sprite_addr_gen.sv
// Sprite hit-test, ROM address generation and duck/dog animation for the colour mapper.
// Optional DUCK_MIRROR_EN: duck_dir=1 flips the duck horizontally (dx -> 63-dx).

module sprite_hit #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] ox,
  input  logic [9:0] oy,
  output logic       hit,
  output logic [5:0] dx,
  output logic [5:0] dy
);
  logic [10:0] x, y, ox_w, oy_w;
  assign x    = {1'b0, px};
  assign y    = {1'b0, py};
  assign ox_w = {1'b0, ox};
  assign oy_w = {1'b0, oy};

  // 11-bit compare so a sprite near the right/bottom edge cannot wrap to column/row 0
  assign hit = (x >= ox_w) && (x < ox_w + 11'd64) &&
               (y >= oy_w) && (y < oy_w + 11'd64) &&
               (x < 11'(H_ACTIVE)) && (y < 11'(V_ACTIVE));
  assign dx  = px[5:0] - ox[5:0];
  assign dy  = py[5:0] - oy[5:0];
endmodule

module sprite_addr_gen #(
  parameter int ANIM_DIV = 8,
  parameter int HIT_HOLD = 30,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  duck_x,
  input  logic [9:0]  duck_y,
  input  logic [9:0]  dog_x,
  input  logic [9:0]  dog_y,
  input  logic        duck_dir,
  input  logic        duck_shot,
  input  logic        duck_respawn,
  input  logic        dog_show,
  output logic        is_duck,
  output logic        is_dog,
  output logic [15:0] duck_addr,
  output logic [13:0] dog_addr,
  output logic        duck_falling
);
  localparam int NSPR = 2;  // 0 = duck, 1 = dog

  typedef enum logic [1:0] {FLY, HIT, FALL} duck_st_t;

  duck_st_t  state, state_n;
  logic [1:0] flap, flap_n, dog_frame, dog_frame_n;
  logic [7:0] hold, hold_n, div, div_n;
  logic       frame_q, armed, tick, step;
  logic [2:0] duck_frame;

  logic [NSPR-1:0][9:0] org_x, org_y;
  logic [NSPR-1:0][5:0] dx, dy;
  logic [NSPR-1:0]      hit;
  logic [5:0]           duck_dx;

  assign org_x = {dog_x, duck_x};
  assign org_y = {dog_y, duck_y};

  genvar g;
  generate
    for (g = 0; g < NSPR; g++) begin : g_spr
      sprite_hit #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_hit (
        .px(DrawX), .py(DrawY), .ox(org_x[g]), .oy(org_y[g]),
        .hit(hit[g]), .dx(dx[g]), .dy(dy[g])
      );
    end
  endgenerate

`ifdef DUCK_MIRROR_EN
  assign duck_dx = duck_dir ? ~dx[0] : dx[0];
`else
  logic unused_dir;
  assign unused_dir = duck_dir;
  assign duck_dx    = dx[0];
`endif

  // armed suppresses a false edge when frame_clk is already high at reset release
  assign tick = armed && frame_clk && !frame_q;
  assign step = tick && (div == 8'(ANIM_DIV - 1));

  always_comb begin
    state_n     = state;
    flap_n      = flap;
    hold_n      = hold;
    div_n       = div;
    dog_frame_n = dog_frame;
    if (tick) div_n = step ? 8'd0 : div + 8'd1;
    if (duck_respawn) begin
      state_n = FLY;
      flap_n  = 2'd0;
    end else begin
      case (state)
        FLY: begin
          if (duck_shot) begin
            state_n = HIT;
            hold_n  = 8'd0;
            div_n   = 8'd0;
          end else if (step) begin
            flap_n = (flap == 2'd2) ? 2'd0 : flap + 2'd1;
          end
        end
        HIT: begin
          if (tick) begin
            hold_n = hold + 8'd1;
            if (hold + 8'd1 == 8'(HIT_HOLD)) state_n = FALL;
          end
        end
        default: ;
      endcase
    end
    if (!dog_show)  dog_frame_n = 2'd0;
    else if (step)  dog_frame_n = dog_frame + 2'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= FLY;
      flap      <= 2'd0;
      hold      <= 8'd0;
      div       <= 8'd0;
      dog_frame <= 2'd0;
      frame_q   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      flap      <= flap_n;
      hold      <= hold_n;
      div       <= div_n;
      dog_frame <= dog_frame_n;
      frame_q   <= frame_clk;
      armed     <= 1'b1;
    end
  end

  always_comb begin
    duck_frame = {1'b0, flap};
    if (state == HIT)  duck_frame = 3'd3;
    if (state == FALL) duck_frame = 3'd4;
  end

  assign duck_falling = (state == FALL);

  // duck drawn in front of the dog
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_duck   <= 1'b0;
      is_dog    <= 1'b0;
      duck_addr <= '0;
      dog_addr  <= '0;
    end else begin
      is_duck   <= hit[0];
      is_dog    <= hit[1] && dog_show && !hit[0];
      duck_addr <= hit[0] ? {1'b0, duck_frame, dy[0], duck_dx} : 16'd0;
      dog_addr  <= (hit[1] && dog_show && !hit[0]) ? {dog_frame, dy[1], dx[1]} : 14'd0;
    end
  end
endmodule

// File: tb/tb_sprite_addr_gen.sv
// Self-checking bench for sprite_addr_gen: vector table, animation sequences, randomized pixels.
// Honours DUCK_MIRROR_EN in its reference model.

module tb_sprite_addr_gen;
`ifdef DUCK_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic        Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, duck_x = '0, duck_y = '0, dog_x = '0, dog_y = '0;
  logic        duck_dir = 1'b0, duck_shot = 1'b0, duck_respawn = 1'b0, dog_show = 1'b0;
  logic        is_duck, is_dog, duck_falling;
  logic [15:0] duck_addr;
  logic [13:0] dog_addr;

  int tests = 0, fails = 0;

  sprite_addr_gen #(.ANIM_DIV(2), .HIT_HOLD(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .duck_x(duck_x), .duck_y(duck_y),
    .dog_x(dog_x), .dog_y(dog_y), .duck_dir(duck_dir), .duck_shot(duck_shot),
    .duck_respawn(duck_respawn), .dog_show(dog_show),
    .is_duck(is_duck), .is_dog(is_dog), .duck_addr(duck_addr), .dog_addr(dog_addr),
    .duck_falling(duck_falling)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int px, py, dkx, dky, dgx, dgy;
    bit dir, show;
    bit e_duck, e_dog;
    int e_daddr, e_gaddr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clk(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1; clk(2);
    frame_clk = 1'b0; clk(2);
  endtask

  task automatic pulse_ctl(input bit shot, input bit resp);
    duck_shot = shot; duck_respawn = resp; clk(1);
    duck_shot = 1'b0; duck_respawn = 1'b0; clk(1);
  endtask

  // Reference: the screen-space geometry from first principles
  task automatic model(input vec_t v, input int dframe, input int gframe,
                       output bit e_duck, output bit e_dog, output int e_da, output int e_ga);
    bit in_dk, in_dg;
    int ddx;
    in_dk = v.px >= v.dkx && v.px < v.dkx + 64 && v.py >= v.dky && v.py < v.dky + 64 &&
            v.px < 640 && v.py < 480;
    in_dg = v.px >= v.dgx && v.px < v.dgx + 64 && v.py >= v.dgy && v.py < v.dgy + 64 &&
            v.px < 640 && v.py < 480;
    e_duck = in_dk;
    e_dog  = in_dg && v.show && !in_dk;
    ddx    = v.px - v.dkx;
    if (MIR && v.dir) ddx = 63 - ddx;
    e_da = e_duck ? dframe * 4096 + (v.py - v.dky) * 64 + ddx : 0;
    e_ga = e_dog  ? gframe * 4096 + (v.py - v.dgy) * 64 + (v.px - v.dgx) : 0;
  endtask

  task automatic apply(input vec_t v);
    DrawX = 10'(v.px); DrawY = 10'(v.py);
    duck_x = 10'(v.dkx); duck_y = 10'(v.dky);
    dog_x = 10'(v.dgx); dog_y = 10'(v.dgy);
    duck_dir = v.dir; dog_show = v.show;
    clk(1);
  endtask

  task automatic rand_block(input int n, input int dframe, input string tag);
    vec_t v;
    bit ed, eg;
    int ea, ga;
    for (int i = 0; i < n; i++) begin
      v.dkx = $urandom_range(0, 700); v.dky = $urandom_range(0, 520);
      v.dgx = $urandom_range(0, 700); v.dgy = $urandom_range(0, 520);
      if ($urandom_range(0, 3) != 0) begin
        v.px = ($urandom_range(0, 1) ? v.dkx : v.dgx) + $urandom_range(0, 72) - 4;
        v.py = ($urandom_range(0, 1) ? v.dky : v.dgy) + $urandom_range(0, 72) - 4;
        if (v.px < 0) v.px = 0;
        if (v.py < 0) v.py = 0;
        if (v.px > 1023) v.px = 1023;
        if (v.py > 1023) v.py = 1023;
      end else begin
        v.px = $urandom_range(0, 1023); v.py = $urandom_range(0, 1023);
      end
      v.dir = 1'($urandom_range(0, 1)); v.show = 1'($urandom_range(0, 1));
      model(v, dframe, 0, ed, eg, ea, ga);
      apply(v);
      chk({tag, " is_duck"}, int'(is_duck), int'(ed));
      chk({tag, " is_dog"}, int'(is_dog), int'(eg));
      chk({tag, " duck_addr"}, int'(duck_addr), ea);
      chk({tag, " dog_addr"}, int'(dog_addr), ga);
    end
  endtask

  vec_t tv[12];
  int flap_exp[4] = '{0, 1, 2, 0};
  int dog_exp[4]  = '{0, 1, 2, 3};

  initial begin
    tv[0]  = '{110, 60,  100, 50,  500, 400, 0, 1, 1, 0, 'h28A, 0};
    tv[1]  = '{164, 60,  100, 50,  500, 400, 0, 1, 0, 0, 0, 0};
    tv[2]  = '{163, 113, 100, 50,  500, 400, 0, 1, 1, 0, 4095, 0};
    tv[3]  = '{200, 200, 200, 200, 200, 200, 0, 1, 1, 0, 0, 0};
    tv[4]  = '{210, 205, 100, 50,  200, 200, 0, 0, 0, 0, 0, 0};
    tv[5]  = '{210, 205, 100, 50,  200, 200, 0, 1, 0, 1, 0, 330};
    tv[6]  = '{639, 0,   0,   100, 620, 0,   0, 1, 0, 1, 0, 19};
    tv[7]  = '{640, 0,   0,   100, 620, 0,   0, 1, 0, 0, 0, 0};
    tv[8]  = '{0,   0,   0,   0,   500, 400, 1, 1, 1, 0, MIR ? 63 : 0, 0};
    tv[9]  = '{5,   479, 300, 0,   0,   450, 0, 1, 0, 1, 0, 1861};
    tv[10] = '{5,   480, 300, 0,   0,   450, 0, 1, 0, 0, 0, 0};
    tv[11] = '{99,  50,  100, 50,  500, 400, 0, 1, 0, 0, 0, 0};

    clk(3);
    chk("reset is_duck", int'(is_duck), 0);
    chk("reset duck_addr", int'(duck_addr), 0);
    chk("reset falling", int'(duck_falling), 0);
    Reset_n = 1'b1;
    clk(2);

    for (int i = 0; i < 12; i++) begin
      apply(tv[i]);
      chk($sformatf("vec%0d is_duck", i), int'(is_duck), int'(tv[i].e_duck));
      chk($sformatf("vec%0d is_dog", i), int'(is_dog), int'(tv[i].e_dog));
      chk($sformatf("vec%0d duck_addr", i), int'(duck_addr), tv[i].e_daddr);
      chk($sformatf("vec%0d dog_addr", i), int'(dog_addr), tv[i].e_gaddr);
    end

    rand_block(150, 0, "rnd_fly");

    // Animation: two ticks per step with ANIM_DIV=2
    duck_x = 100; duck_y = 50; dog_x = 300; dog_y = 300; dog_show = 1'b1; duck_dir = 1'b0;
    clk(1);
    for (int k = 0; k < 4; k++) begin
      DrawX = 100; DrawY = 50; clk(1);
      chk($sformatf("flap%0d duck_addr", k), int'(duck_addr), flap_exp[k] * 4096);
      DrawX = 300; DrawY = 300; clk(1);
      chk($sformatf("dogframe%0d dog_addr", k), int'(dog_addr), dog_exp[k] * 4096);
      if (k < 3) begin
        frame_pulse(); frame_pulse();
      end
    end

    // Hit / hold / fall
    dog_show = 1'b0; DrawX = 100; DrawY = 50;
    pulse_ctl(1'b1, 1'b0);
    chk("hit base", int'(duck_addr), 'h3000);
    chk("hit falling", int'(duck_falling), 0);
    frame_pulse();
    chk("hold1 base", int'(duck_addr), 'h3000);
    frame_pulse();
    chk("hold2 base", int'(duck_addr), 'h3000);
    frame_pulse();
    chk("fall base", int'(duck_addr), 'h4000);
    chk("fall falling", int'(duck_falling), 1);
    pulse_ctl(1'b1, 1'b0);
    chk("shot in fall ignored", int'(duck_addr), 'h4000);

    rand_block(80, 4, "rnd_fall");

    duck_x = 100; duck_y = 50; DrawX = 100; DrawY = 50; duck_dir = 1'b0;
    pulse_ctl(1'b0, 1'b1);
    chk("respawn base", int'(duck_addr), 0);
    chk("respawn falling", int'(duck_falling), 0);

    pulse_ctl(1'b1, 1'b1);
    chk("shot+respawn stays fly", int'(duck_addr), 0);
    pulse_ctl(1'b1, 1'b0);
    chk("hit again base", int'(duck_addr), 'h3000);
    pulse_ctl(1'b0, 1'b1);
    chk("respawn from hit", int'(duck_addr), 0);

    // frame_clk high across reset release must not count as a tick
    frame_clk = 1'b1; Reset_n = 1'b0; clk(2);
    Reset_n = 1'b1; clk(3);
    frame_clk = 1'b0; clk(2);
    frame_pulse();
    chk("no tick at release", int'(duck_addr), 0);
    frame_pulse();
    chk("first step after release", int'(duck_addr), 'h1000);

    // Asynchronous reset mid-frame
    dog_show = 1'b1; dog_x = 300; dog_y = 300; DrawX = 310; DrawY = 310; clk(1);
    chk("pre-reset is_dog", int'(is_dog), 1);
    DrawX = 100; DrawY = 50; clk(1);
    chk("pre-reset duck_addr", int'(duck_addr), 'h1000);
    #3 Reset_n = 1'b0;
    #1;
    chk("async is_duck", int'(is_duck), 0);
    chk("async duck_addr", int'(duck_addr), 0);
    chk("async dog_addr", int'(dog_addr), 0);
    clk(2);
    Reset_n = 1'b1; clk(2);
    chk("post-reset flap0", int'(duck_addr), 0);
    chk("post-reset is_duck", int'(is_duck), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
